fetch_unit: RTL and testbench

Instruction-fetch front end that sits directly upstream of the CPU datapath/decoder. It owns the program counter and the run/start/ack handshake with the test harness, and drives the instruction ROM address. It presents each 9-bit instruction to the core and resolves next-PC through a small branch-target lookup table, since 9-bit instructions cannot hold full addresses. It raises Ack when the core signals halt, or when the PC runs off the end of program space.

---
 rtl/fetch_unit_pkg.sv | 35 +++
 rtl/fetch_unit_branch_lut.sv | 35 +++
 rtl/fetch_unit.sv | 112 +++++++++++
 tb/tb_fetch_unit.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch front end and its neighbours
// (decoder reuses HALT_OPCODE).
package fetch_unit_pkg;

  localparam int PC_W      = 10;
  localparam int INSTR_W   = 9;
  localparam int LUT_IDX_W = 5;
  localparam int LUT_DEPTH = 1 << LUT_IDX_W;

  localparam logic [PC_W-1:0] START0 = 10'd0;
  localparam logic [PC_W-1:0] START1 = 10'd128;
  localparam logic [PC_W-1:0] START2 = 10'd256;
  localparam logic [PC_W-1:0] START3 = 10'd384;
  localparam logic [PC_W-1:0] PC_MAX = '1;

  localparam logic [INSTR_W-1:0] HALT_OPCODE = 9'h1FF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [PC_W-1:0] start_addr(input logic [1:0] sel);
    logic [PC_W-1:0] addr;
    case (sel)
      2'd0:    addr = START0;
      2'd1:    addr = START1;
      2'd2:    addr = START2;
      default: addr = START3;
    endcase
    return addr;
  endfunction

endpackage

// File: rtl/fetch_unit_branch_lut.sv
// Branch-target table: one synchronous write port, one combinational read port,
// contents cleared by the asynchronous reset.
module branch_lut
  import fetch_unit_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [LUT_IDX_W-1:0] waddr,
  input  logic [PC_W-1:0]      wdata,
  input  logic [LUT_IDX_W-1:0] raddr,
  output logic [PC_W-1:0]      rdata
);

  logic [PC_W-1:0] mem_q [LUT_DEPTH];
  logic [PC_W-1:0] mem_d [LUT_DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  // NOTE: this table is built from flops, so clearing every entry on reset is
  // cheap and intended; a branch after reset must land on address 0, not X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LUT_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC and the Start/Ack handshake, and
// resolves branch targets through branch_lut.
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic [1:0]           ProgSel,
  input  logic                 Halt,
  input  logic                 BranchTaken,
  input  logic [LUT_IDX_W-1:0] BranchIdx,
  input  logic                 LutWe,
  input  logic [LUT_IDX_W-1:0] LutWaddr,
  input  logic [PC_W-1:0]      LutWdata,
  output logic [PC_W-1:0]      RomAddr,
  input  logic [INSTR_W-1:0]   RomData,
  output logic [INSTR_W-1:0]   Instruction,
  output logic                 InstrValid,
  output logic [PC_W-1:0]      PgmCtr,
  output logic                 Ack,
  output logic                 Fault
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            fault_q, fault_d;
  logic            start_q, start_d;
  logic            launch;
  logic            lut_we;
  logic [PC_W-1:0] branch_target;

  assign start_d = Start;
  assign launch  = Start & ~start_q;

  // The table is frozen while a program runs so a branch never races a write.
  assign lut_we = LutWe & (state_q != ST_RUN);

  branch_lut u_branch_lut (
    .clk   (Clk),
    .rst_n (Reset),
    .we    (lut_we),
    .waddr (LutWaddr),
    .wdata (LutWdata),
    .raddr (BranchIdx),
    .rdata (branch_target)
  );

  // NOTE: every variable gets its default first so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fault_d = fault_q;
    case (state_q)
      ST_IDLE: begin
        if (launch) begin
          pc_d    = start_addr(ProgSel);
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (Halt) begin
          state_d = ST_DONE;
        end else if (BranchTaken) begin
          pc_d = branch_target;
        end else if (pc_q == PC_MAX) begin
          state_d = ST_DONE;
          fault_d = 1'b1;
        end else begin
          pc_d = pc_q + PC_W'(1);
        end
      end
      ST_DONE: begin
        if (launch) begin
          pc_d    = start_addr(ProgSel);
          fault_d = 1'b0;
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        pc_d    = '0;
        fault_d = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples its _d value from before the edge.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      fault_q <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
      start_q <= start_d;
    end
  end

  assign RomAddr     = pc_q;
  assign PgmCtr      = pc_q;
  assign InstrValid  = (state_q == ST_RUN);
  assign Instruction = InstrValid ? RomData : '0;
  assign Ack         = (state_q == ST_DONE);
  assign Fault       = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected fetch state is queued when the
// stimulus is driven and compared just after the following clock edge.
module tb_fetch_unit;

  logic       Clk;
  logic       Reset;
  logic       Start;
  logic [1:0] ProgSel;
  logic       Halt;
  logic       BranchTaken;
  logic [4:0] BranchIdx;
  logic       LutWe;
  logic [4:0] LutWaddr;
  logic [9:0] LutWdata;
  logic [9:0] RomAddr;
  logic [8:0] RomData;
  logic [8:0] Instruction;
  logic       InstrValid;
  logic [9:0] PgmCtr;
  logic       Ack;
  logic       Fault;

  typedef struct packed {
    logic [9:0] pc;
    logic       valid;
    logic       ack;
    logic       fault;
  } exp_t;

  exp_t sb_q[$];
  int   chk_cnt  = 0;
  int   pass_cnt = 0;

  fetch_unit dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Start       (Start),
    .ProgSel     (ProgSel),
    .Halt        (Halt),
    .BranchTaken (BranchTaken),
    .BranchIdx   (BranchIdx),
    .LutWe       (LutWe),
    .LutWaddr    (LutWaddr),
    .LutWdata    (LutWdata),
    .RomAddr     (RomAddr),
    .RomData     (RomData),
    .Instruction (Instruction),
    .InstrValid  (InstrValid),
    .PgmCtr      (PgmCtr),
    .Ack         (Ack),
    .Fault       (Fault)
  );

  function automatic logic [8:0] rom_f(input logic [9:0] a);
    logic [31:0] v;
    v = 32'(a) * 32'd5 + 32'd7;
    return v[8:0];
  endfunction

  assign RomData = rom_f(RomAddr);

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic push(input logic [9:0] pc, input logic valid, input logic ack,
                      input logic fault);
    exp_t e;
    e.pc = pc; e.valid = valid; e.ack = ack; e.fault = fault;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge Clk);
    #1;
    if (sb_q.size() == 0) begin
      check("sb_underflow", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check("pc",         32'(PgmCtr),      32'(e.pc));
      check("rom_addr",   32'(RomAddr),     32'(e.pc));
      check("valid",      32'(InstrValid),  32'(e.valid));
      check("instr",      32'(Instruction), e.valid ? 32'(rom_f(e.pc)) : 32'd0);
      check("ack",        32'(Ack),         32'(e.ack));
      check("fault",      32'(Fault),       32'(e.fault));
    end
  endtask

  task automatic run_one(input logic [9:0] pc);
    push(pc, 1'b1, 1'b0, 1'b0);
    tick();
  endtask

  initial begin
    Reset = 1'b0; Start = 1'b0; ProgSel = 2'd0; Halt = 1'b0;
    BranchTaken = 1'b0; BranchIdx = '0; LutWe = 1'b0; LutWaddr = '0; LutWdata = '0;

    #3;
    check("rst_pc",    32'(PgmCtr),      32'd0);
    check("rst_valid", 32'(InstrValid),  32'd0);
    check("rst_ack",   32'(Ack),         32'd0);
    check("rst_fault", 32'(Fault),       32'd0);
    check("rst_instr", 32'(Instruction), 32'd0);
    #9 Reset = 1'b1;

    // IDLE: LUT[3] = 300
    LutWe = 1'b1; LutWaddr = 5'd3; LutWdata = 10'd300;
    push(10'd0, 1'b0, 1'b0, 1'b0); tick();
    LutWe = 1'b0;

    // Program 1, Start held high through the halt
    Start = 1'b1; ProgSel = 2'd1;
    for (int p = 128; p <= 131; p++) run_one(10'(p));
    Halt = 1'b1;
    push(10'd131, 1'b0, 1'b1, 1'b0); tick();
    Halt = 1'b0;
    for (int i = 0; i < 2; i++) begin
      push(10'd131, 1'b0, 1'b1, 1'b0); tick();
    end
    Start = 1'b0;
    push(10'd131, 1'b0, 1'b1, 1'b0); tick();

    // Program 0: LUT write during RUN is ignored, branch goes to 300
    Start = 1'b1; ProgSel = 2'd0;
    run_one(10'd0);
    Start = 1'b0;
    run_one(10'd1);
    run_one(10'd2);
    LutWe = 1'b1; LutWaddr = 5'd3; LutWdata = 10'd40;
    run_one(10'd3);
    LutWe = 1'b0;
    run_one(10'd4);
    run_one(10'd5);
    BranchTaken = 1'b1; BranchIdx = 5'd3;
    run_one(10'd300);
    BranchTaken = 1'b0;
    run_one(10'd301);
    Halt = 1'b1; BranchTaken = 1'b1;
    push(10'd301, 1'b0, 1'b1, 1'b0); tick();
    Halt = 1'b0; BranchTaken = 1'b0;

    // Halt and branch together at PC 5: halt wins
    Start = 1'b1; ProgSel = 2'd0;
    run_one(10'd0);
    Start = 1'b0;
    for (int p = 1; p <= 5; p++) run_one(10'(p));
    Halt = 1'b1; BranchTaken = 1'b1; BranchIdx = 5'd3;
    push(10'd5, 1'b0, 1'b1, 1'b0); tick();
    Halt = 1'b0; BranchTaken = 1'b0;

    // DONE: LUT write honoured, branch goes to 40
    LutWe = 1'b1; LutWaddr = 5'd3; LutWdata = 10'd40;
    push(10'd5, 1'b0, 1'b1, 1'b0); tick();
    LutWe = 1'b0;
    Start = 1'b1; ProgSel = 2'd0;
    run_one(10'd0);
    Start = 1'b0;
    run_one(10'd1);
    run_one(10'd2);
    BranchTaken = 1'b1; BranchIdx = 5'd3;
    run_one(10'd40);
    BranchTaken = 1'b0;
    run_one(10'd41);
    Halt = 1'b1;
    push(10'd41, 1'b0, 1'b1, 1'b0); tick();
    Halt = 1'b0;

    // Program 3 runs off the end of program space
    Start = 1'b1; ProgSel = 2'd3;
    run_one(10'd384);
    Start = 1'b0;
    for (int p = 385; p <= 1023; p++) run_one(10'(p));
    for (int i = 0; i < 2; i++) begin
      push(10'd1023, 1'b0, 1'b1, 1'b1); tick();
    end

    // Relaunch clears Ack and Fault
    Start = 1'b1; ProgSel = 2'd2;
    run_one(10'd256);
    Start = 1'b0;
    run_one(10'd257);
    Halt = 1'b1;
    push(10'd257, 1'b0, 1'b1, 1'b0); tick();
    Halt = 1'b0;

    // Program 1 up to PC 200, then asynchronous reset between edges
    Start = 1'b1; ProgSel = 2'd1;
    run_one(10'd128);
    Start = 1'b0;
    for (int p = 129; p <= 200; p++) run_one(10'(p));
    #3 Reset = 1'b0;
    #1;
    check("arst_pc",    32'(PgmCtr),      32'd0);
    check("arst_valid", 32'(InstrValid),  32'd0);
    check("arst_ack",   32'(Ack),         32'd0);
    check("arst_instr", 32'(Instruction), 32'd0);
    #2 Reset = 1'b1;
    push(10'd0, 1'b0, 1'b0, 1'b0); tick();

    // LUT cleared by reset: branch on index 3 lands on 0
    Start = 1'b1; ProgSel = 2'd0;
    run_one(10'd0);
    Start = 1'b0;
    run_one(10'd1);
    run_one(10'd2);
    BranchTaken = 1'b1; BranchIdx = 5'd3;
    run_one(10'd0);
    BranchTaken = 1'b0;
    run_one(10'd1);
    Halt = 1'b1;
    push(10'd1, 1'b0, 1'b1, 1'b0); tick();
    Halt = 1'b0;

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
